// File: rtl/obstacle_scheduler.sv
// Round-robin spawn scheduler for the obstacle lanes, paced by game_en.
// Define OBSTACLE_SCHED_LEVEL_RAMP_EN to enable level counting and gap shrink.
module obstacle_scheduler #(
    parameter int         NUM_SLOTS        = 4,
    parameter logic [7:0] BASE_GAP         = 8'd24,
    parameter logic [7:0] MIN_GAP          = 8'd6,
    parameter logic [7:0] GAP_STEP         = 8'd3,
    parameter logic [3:0] SPAWNS_PER_LEVEL = 4'd8,
    parameter logic [2:0] MAX_LEVEL        = 3'd7,
    parameter logic [9:0] AMP_MASK         = 10'd127,
    parameter logic [7:0] ACK_TIMEOUT      = 8'd4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 game_en,
    input  logic                 game_active,
    input  logic                 collision,
    input  logic [NUM_SLOTS-1:0] slot_idle,
    input  logic [NUM_SLOTS-1:0] slot_ack,
    input  logic [9:0]           rand_in,
    output logic [NUM_SLOTS-1:0] spawn_req,
    output logic [9:0]           y_amplitude_out,
    output logic [2:0]           level,
    output logic [15:0]          spawn_count,
    output logic                 halted
);

    localparam int PW = $clog2(NUM_SLOTS);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_PICK, S_GRANT, S_HALT
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic [7:0]           ack_cnt_q, ack_cnt_d;
    logic [PW-1:0]        rr_q, rr_d;
    logic [PW-1:0]        grant_q, grant_d;
    logic [NUM_SLOTS-1:0] req_q, req_d;
    logic [9:0]           amp_q, amp_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 coll_q;

    logic                 halt_now, ack_hit;
    logic [7:0]           gap_now, gap_next, ack_inc;
    logic                 pick_found;
    logic [PW-1:0]        pick_idx, rr_inc;
    logic [PW:0]          scan, grant_inc;

    assign halt_now  = coll_q | collision;
    assign ack_hit   = game_en & ~halt_now & game_active
                     & (state_q == S_GRANT) & slot_ack[grant_q];
    assign ack_inc   = ack_cnt_q + 8'd1;
    assign grant_inc = {1'b0, grant_q} + {{PW{1'b0}}, 1'b1};
    assign rr_inc    = (grant_inc == (PW+1)'(NUM_SLOTS)) ? '0 : grant_inc[PW-1:0];

`ifdef OBSTACLE_SCHED_LEVEL_RAMP_EN
    logic [2:0] level_q, level_d;
    logic [3:0] lvl_cnt_q, lvl_cnt_d;

    // Compare before subtracting so the gap never wraps below the floor.
    function automatic logic [7:0] gap_of(input logic [2:0] lv);
        logic [10:0] prod;
        logic [7:0]  diff;
        prod = 11'(lv) * 11'(GAP_STEP);
        if (prod >= 11'(BASE_GAP)) return MIN_GAP;
        diff = BASE_GAP - prod[7:0];
        return (diff < MIN_GAP) ? MIN_GAP : diff;
    endfunction

    always_comb begin
        level_d   = level_q;
        lvl_cnt_d = lvl_cnt_q;
        if (ack_hit) begin
            if (lvl_cnt_q + 4'd1 == SPAWNS_PER_LEVEL) begin
                lvl_cnt_d = '0;
                if (level_q != MAX_LEVEL) level_d = level_q + 3'd1;
            end else begin
                lvl_cnt_d = lvl_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= '0;
            lvl_cnt_q <= '0;
        end else begin
            level_q   <= level_d;
            lvl_cnt_q <= lvl_cnt_d;
        end
    end

    assign gap_now  = gap_of(level_q);
    assign gap_next = gap_of(level_d);
    assign level    = level_q;
`else
    assign gap_now  = BASE_GAP;
    assign gap_next = BASE_GAP;
    assign level    = 3'd0;
`endif

    // Cyclic scan for the first idle lane at or after the round-robin pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            scan = {1'b0, rr_q} + (PW+1)'(i);
            if (scan >= (PW+1)'(NUM_SLOTS)) scan = scan - (PW+1)'(NUM_SLOTS);
            if (!pick_found && slot_idle[scan[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        ack_cnt_d = ack_cnt_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        req_d     = req_q;
        amp_d     = amp_q;
        cnt_d     = cnt_q;
        if (game_en) begin
            if (halt_now) begin
                state_d = S_HALT;
                req_d   = '0;
            end else if (!game_active) begin
                state_d = S_IDLE;
                req_d   = '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        gap_cnt_d = gap_now;
                        state_d   = (gap_now == 8'd0) ? S_PICK : S_GAP;
                    end
                    S_GAP: begin
                        gap_cnt_d = gap_cnt_q - 8'd1;
                        if (gap_cnt_q <= 8'd1) state_d = S_PICK;
                    end
                    S_PICK: begin
                        if (pick_found) begin
                            req_d           = '0;
                            req_d[pick_idx] = 1'b1;
                            grant_d         = pick_idx;
                            amp_d           = rand_in & AMP_MASK;
                            ack_cnt_d       = '0;
                            state_d         = S_GRANT;
                        end
                    end
                    S_GRANT: begin
                        if (slot_ack[grant_q]) begin
                            req_d     = '0;
                            rr_d      = rr_inc;
                            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                            gap_cnt_d = gap_next;
                            state_d   = (gap_next == 8'd0) ? S_PICK : S_GAP;
                        end else begin
                            ack_cnt_d = ack_inc;
                            if (ack_inc >= ACK_TIMEOUT) begin
                                req_d     = '0;
                                rr_d      = rr_inc;
                                gap_cnt_d = gap_now;
                                state_d   = (gap_now == 8'd0) ? S_PICK : S_GAP;
                            end
                        end
                    end
                    S_HALT: req_d = '0;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
            ack_cnt_q <= '0;
            rr_q      <= '0;
            grant_q   <= '0;
            req_q     <= '0;
            amp_q     <= '0;
            cnt_q     <= '0;
            coll_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            ack_cnt_q <= ack_cnt_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            req_q     <= req_d;
            amp_q     <= amp_d;
            cnt_q     <= cnt_d;
            coll_q    <= coll_q | collision;
        end
    end

    assign spawn_req       = req_q;
    assign y_amplitude_out = amp_q;
    assign spawn_count     = cnt_q;
    assign halted          = (state_q == S_HALT);

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Spawn scheduler for a bank of `obstacle_control` lanes.
- Decides when the next obstacle may launch and which idle lane launches it, using round-robin selection.
- Supplies each launch with a masked random arc amplitude.
- Shortens the inter-spawn gap as the difficulty level rises.
- Sits between the random generator, the collision detector and the obstacle lanes. All activity is paced by the game clock enable.

## Interface
- `NUM_SLOTS`, 4: number of obstacle lanes scheduled (2..8).
- `BASE_GAP`, 8'd24: inter-spawn gap at level 0, in `game_en` ticks.
- `MIN_GAP`, 8'd6: gap floor.
- `GAP_STEP`, 8'd3: gap reduction per level.
- `SPAWNS_PER_LEVEL`, 4'd8: acknowledged spawns needed to advance one level.
- `MAX_LEVEL`, 3'd7: level saturation value.
- `AMP_MASK`, 10'd127: mask applied to `rand_in` to form the amplitude.
- `ACK_TIMEOUT`, 8'd4: ticks to wait for a lane acknowledge before abandoning the grant.

Ports:
- `clk` input 1: 50 MHz system clock.
- `rst` input 1: synchronous, active-high reset.
- `game_en` input 1: one-`clk` game tick enable.
- `game_active` input 1: game running.
- `collision` input 1: collision detector output.
- `slot_idle` input NUM_SLOTS: lane is in its wait state and spawnable.
- `slot_ack` input NUM_SLOTS: lane has accepted its spawn.
- `rand_in` input 10: random generator value.
- `spawn_req` output NUM_SLOTS: one-hot spawn request.
- `y_amplitude_out` output 10: amplitude for the granted lane.
- `level` output 3: current difficulty level.
- `spawn_count` output 16: acknowledged spawns, saturating.
- `halted` output 1: scheduler is stopped by a collision.

## Operation
- States: S_IDLE, S_GAP, S_PICK, S_GRANT, S_HALT.
- Reset values:
  - State is S_IDLE.
  - All outputs are 0.
  - `gap_cnt`, `ack_cnt`, `rr_ptr` and the per-level spawn counter are 0.
  - The collision latch is cleared.
- `collision` is latched sticky on any `clk` cycle. The latch clears only on reset.
- The FSM, counters and outputs update only on cycles where `game_en`=1.
- Priority on each tick: collision latch → S_HALT, then `!game_active` → S_IDLE, then the normal transitions below.
- S_IDLE: `spawn_req`=0.
  - On a tick with `game_active`=1, load `gap_cnt` with the current gap and go to S_GAP.
- S_GAP: decrement `gap_cnt` each tick.
  - On the tick where `gap_cnt`==1, go to S_PICK.
  - If the gap is 0, skip S_GAP.
- S_PICK: select the first `slot_idle` bit at or after `rr_ptr`, scanning cyclically.
  - If none is set, stay in S_PICK with `spawn_req`=0.
  - Otherwise register a one-hot `spawn_req` for the selected lane.
  - Latch `y_amplitude_out` = `rand_in` & `AMP_MASK`.
  - Clear `ack_cnt` and go to S_GRANT.
- S_GRANT: hold `spawn_req` and `y_amplitude_out` stable.
  - If `slot_ack` of the granted lane is 1:
    - Clear `spawn_req`.
    - Set `rr_ptr` = granted+1 mod NUM_SLOTS.
    - Increment `spawn_count`, saturating at 16'hFFFF.
    - Run the level update.
    - Reload `gap_cnt` and go to S_GAP.
  - Otherwise increment `ack_cnt`. When `ack_cnt` reaches `ACK_TIMEOUT`:
    - Clear `spawn_req`.
    - Advance `rr_ptr` past the granted lane.
    - Leave count and level unchanged.
    - Reload the gap and go to S_GAP.
  - `slot_ack` bits of non-granted lanes are ignored.
- S_HALT: `spawn_req`=0 and `halted`=1.
  - Only reset exits S_HALT.
- Level update:
  - The per-level counter increments on each acknowledged spawn.
  - When it reaches `SPAWNS_PER_LEVEL`, it returns to 0 and `level` increments, saturating at `MAX_LEVEL`.
- Gap arithmetic: gap = `BASE_GAP` − `level`·`GAP_STEP`, floored at `MIN_GAP`.
  - Compute the product at 11 bits.
  - Compare before subtracting so the result never wraps.

## Timing
- Ack tick to next `spawn_req` assertion is gap+1 ticks when a lane is idle. The breakdown is gap ticks in S_GAP plus 1 tick in S_PICK.
- `spawn_req` and `y_amplitude_out` are registered and change only on `game_en` cycles.
- A collision on any `clk` cycle clears `spawn_req` and asserts `halted` at the next `game_en` edge. This applies mid-grant as well.
- `game_active` falling mid-grant drops `spawn_req` on that tick without an ack. `rr_ptr` is not advanced.
- Ack and timeout on the same tick: the ack wins.
- When `rr_ptr` points to the last slot, the scan wraps to slot 0.
- `rst` mid-operation overrides everything on the next `clk` edge, regardless of `game_en`.

## Configuration
- `OBSTACLE_SCHED_LEVEL_RAMP_EN` defined: level counting and gap reduction operate as described above.
- `OBSTACLE_SCHED_LEVEL_RAMP_EN` undefined:
  - `level` is tied to 0.
  - The per-level counter is removed.
  - The gap is fixed at `BASE_GAP`.
  - `spawn_count` still operates.

## Test plan
- Reset, `game_active`=1, all lanes idle, ack 1 tick after each request → requests in order slot0, 1, 2, 3, 0. Request 1 asserts 25 ticks after `game_active`. Later requests assert 25 ticks after each ack.
- `rand_in`=10'h3FF at PICK → `y_amplitude_out`=10'd127, held constant through GRANT.
- Ramp enabled, 24 acknowledged spawns → `level`=3 and gap 15. After 56 spawns, `level`=7 and gap 6 (floored from 3). Further spawns leave `level` at 7.
- Only slot2 idle and `rr_ptr`=3 → slot2 is granted. No ack for 4 ticks → request drops, `spawn_count` is unchanged, next grant search starts at slot3.
- A one-`clk` `collision` pulse between ticks while in S_GRANT → at the next tick `spawn_req`=0 and `halted`=1. The scheduler stays halted until `rst`.
- Macro undefined, 100 spawns → `level`=0, gap stays 24, `spawn_count`=100.
